// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// Ratio changes and start/stop are deferred to output-period boundaries so clk_out never glitches.
module clk_div_prog #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic             ack,
  output logic             err,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             p_q, p_d;
  logic             n_q;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             load_ok;
  logic             boundary;

  assign load_ok  = load && (div_in >= DIV_W'(2));
  assign boundary = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    err_d        = load && !load_ok;

    if (load_ok) begin
      pend_d       = div_in;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load_ok) begin
          div_d        = div_in;
          pend_valid_d = 1'b0;
          ack_d        = 1'b1;
        end else if (pend_valid_q) begin
          div_d        = pend_q;
          pend_valid_d = 1'b0;
          ack_d        = 1'b1;
        end
        if (en) state_d = RUN;
      end
      RUN, STOPPING: begin
        cnt_d = boundary ? '0 : cnt_q + DIV_W'(1);
        if (boundary) begin
          // A load sampled on the boundary itself stays pending for the next boundary.
          if (pend_valid_q) begin
            div_d        = pend_q;
            ack_d        = 1'b1;
            pend_valid_d = load_ok;
          end
          state_d = en ? RUN : IDLE;
        end else begin
          state_d = en ? RUN : STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase

    // p_q is registered from next-state values so it lines up with cnt_q of the same cycle.
    p_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= DIV_W'(DEFAULT_DIV);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      p_q          <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      p_q          <= p_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) n_q <= 1'b0;
    else     n_q <= p_q & div_q[0];
  end

  assign clk_out = p_q | n_q;
  assign tick    = (state_q == RUN) && (cnt_q == '0);
  assign ack     = ack_q;
  assign err     = err_q;
  assign running = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: waveform shape, tick/ack/err pulses, start/stop and ratio changes.
module tb_clk_div_prog;

  typedef enum int unsigned {A_NONE, A_LOAD, A_DROP, A_PULSE, A_STOPLOAD} act_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       load;
  logic       clk_out, tick, ack, err, running;

  int unsigned vectors;
  int unsigned miscompares;

  clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .load    (load),
    .clk_out (clk_out),
    .tick    (tick),
    .ack     (ack),
    .err     (err),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One idle/transition cycle with explicit expectations at posedge+1 and negedge+1.
  task automatic cyc(input string tag, input logic pos, input logic neg, input logic tk,
                     input logic ak, input logic er, input logic rn);
    @(posedge clk); #1;
    load = 1'b0;
    chk({tag, ".clk_pos"}, clk_out, pos);
    chk({tag, ".tick"}, tick, tk);
    chk({tag, ".ack"}, ack, ak);
    chk({tag, ".err"}, err, er);
    chk({tag, ".running"}, running, rn);
    @(negedge clk); #1;
    chk({tag, ".clk_neg"}, clk_out, neg);
  endtask

  // One full output period of ratio n; an optional stimulus action is applied after cycle act_c.
  task automatic period(input int unsigned n, input logic ack0, input int unsigned act_c,
                        input act_t act, input logic [7:0] val);
    int unsigned h;
    logic        ep, en_, ee;
    h = n / 2;
    for (int unsigned c = 0; c < n; c++) begin
      @(posedge clk); #1;
      load = 1'b0;
      ep  = (n % 2 == 1) ? (c <= h) : (c < h);
      en_ = (c < h);
      ee  = (act == A_LOAD) && (val < 8'd2) && (c == act_c + 1);
      chk($sformatf("N%0d.c%0d.clk_pos", n, c), clk_out, ep);
      chk($sformatf("N%0d.c%0d.tick", n, c), tick, c == 0);
      chk($sformatf("N%0d.c%0d.ack", n, c), ack, ack0 && (c == 0));
      chk($sformatf("N%0d.c%0d.err", n, c), err, ee);
      chk($sformatf("N%0d.c%0d.running", n, c), running, 1'b1);
      @(negedge clk); #1;
      chk($sformatf("N%0d.c%0d.clk_neg", n, c), clk_out, en_);
      if (c == act_c) begin
        case (act)
          A_LOAD:     begin load = 1'b1; div_in = val; end
          A_DROP:     en = 1'b0;
          A_PULSE:    en = 1'b0;
          A_STOPLOAD: begin en = 1'b0; load = 1'b1; div_in = val; end
          default: ;
        endcase
      end
      if (act == A_PULSE && c == act_c + 1) en = 1'b1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    div_in = '0;

    // Reset state
    #12;
    chk("rst.clk_out", clk_out, 1'b0);
    chk("rst.tick", tick, 1'b0);
    chk("rst.ack", ack, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.running", running, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    cyc("idle0", 0, 0, 0, 0, 0, 0);

    // Default N=3, first rising edge on the first posedge after en
    en = 1'b1;
    period(3, 0, 0, A_NONE, 0);
    period(3, 0, 0, A_NONE, 0);
    en = 1'b0;
    cyc("stop3", 0, 0, 0, 0, 0, 0);

    // Load 4 in IDLE, then 7 mid-period
    load = 1'b1; div_in = 8'd4;
    cyc("idle_load4", 0, 0, 0, 1, 0, 0);
    en = 1'b1;
    period(4, 0, 1, A_LOAD, 8'd7);
    period(7, 1, 1, A_LOAD, 8'd1);
    period(7, 0, 3, A_LOAD, 8'd0);
    period(7, 0, 2, A_LOAD, 8'd5);

    // N=5 stop request mid-period completes the period
    period(5, 1, 1, A_DROP, 0);
    cyc("stop5a", 0, 0, 0, 0, 0, 0);
    cyc("stop5b", 0, 0, 0, 0, 0, 0);

    // Brief en drop recovered before the boundary: no interruption
    en = 1'b1;
    period(5, 0, 2, A_PULSE, 0);
    period(5, 0, 0, A_NONE, 0);

    // Simultaneous stop and load: both take effect at the same boundary
    period(5, 0, 1, A_STOPLOAD, 8'd255);
    cyc("stopload_ack", 0, 0, 0, 1, 0, 0);
    cyc("stopload_idle", 0, 0, 0, 0, 0, 0);

    // Extreme ratios
    en = 1'b1;
    period(255, 0, 10, A_LOAD, 8'd2);
    period(2, 1, 0, A_NONE, 0);
    period(2, 0, 0, A_LOAD, 8'd6);

    // Load landing exactly on the boundary applies one boundary later
    period(6, 1, 5, A_LOAD, 8'd4);
    period(6, 0, 0, A_NONE, 0);
    period(4, 1, 1, A_LOAD, 8'd6);

    // Reset while clk_out high at N=6
    @(posedge clk); #1;
    chk("n6.c0.clk_pos", clk_out, 1'b1);
    chk("n6.c0.tick", tick, 1'b1);
    chk("n6.c0.ack", ack, 1'b1);
    @(posedge clk); #1;
    chk("n6.c1.clk_pos", clk_out, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst.clk_out", clk_out, 1'b0);
    chk("midrst.running", running, 1'b0);
    chk("midrst.tick", tick, 1'b0);
    en = 1'b0;
    @(negedge clk); #1;
    chk("midrst.hold", clk_out, 1'b0);
    rst = 1'b0;
    cyc("postrst0", 0, 0, 0, 0, 0, 0);
    cyc("postrst1", 0, 0, 0, 0, 0, 0);
    en = 1'b1;
    period(3, 0, 0, A_NONE, 0);
    period(3, 0, 0, A_NONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
